// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: decoded operation codes and divide FSM states.
// Pure declarations, no timing or handshake behaviour.
package alu_pkg;

  localparam int OP_CODE_W = 6;

  typedef enum logic [OP_CODE_W-1:0] {
    OP_ADD    = 6'd1,
    OP_ADDI   = 6'd2,
    OP_SUB    = 6'd3,
    OP_AND    = 6'd4,
    OP_ANDI   = 6'd5,
    OP_OR     = 6'd6,
    OP_ORI    = 6'd7,
    OP_XOR    = 6'd8,
    OP_XORI   = 6'd9,
    OP_SLL    = 6'd10,
    OP_SLLI   = 6'd11,
    OP_SRL    = 6'd12,
    OP_SRLI   = 6'd13,
    OP_SRA    = 6'd14,
    OP_SRAI   = 6'd15,
    OP_SLT    = 6'd16,
    OP_SLTI   = 6'd17,
    OP_SLTU   = 6'd18,
    OP_SLTIU  = 6'd19,
    OP_LUI    = 6'd20,
    OP_AUIPC  = 6'd21,
    OP_MUL    = 6'd22,
    OP_MULH   = 6'd23,
    OP_MULHSU = 6'd24,
    OP_MULHU  = 6'd25,
    OP_DIV    = 6'd26,
    OP_DIVU   = 6'd27,
    OP_REM    = 6'd28,
    OP_REMU   = 6'd29
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_RUN  = 2'd1,
    ST_DIV_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// Issue and write-back bundle between decode/register-read, the ALU and the register file.
// master = issuing stage, slave = ALU; in_ready gates acceptance of in_valid.
interface alu_mdu_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 6
);
  logic            in_valid;
  logic            in_ready;
  logic            jump_branch_enable;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] src1_value;
  logic [XLEN-1:0] src2_value;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd;
  logic [OP_W-1:0] operation_con;
  logic            busy;
  logic            write_req;
  logic [4:0]      write_addr;
  logic [XLEN-1:0] write_data;

  modport master (
    output in_valid, jump_branch_enable, pc, src1_value, src2_value, imm, rd, operation_con,
    input  in_ready, busy, write_req, write_addr, write_data
  );

  modport slave (
    input  in_valid, jump_branch_enable, pc, src1_value, src2_value, imm, rd, operation_con,
    output in_ready, busy, write_req, write_addr, write_data
  );
endinterface

// File: rtl/alu_div_iter.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle after start.
// done pulses the cycle after the XLEN-th step; abort kills the run with no done.
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  dvs;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;
  logic             ge;

  // The dividend shifts out of the quotient register while quotient bits shift in.
  assign shifted = {remainder, quotient[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign ge      = shifted >= {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      dvs       <= '0;
      cnt       <= '0;
      run       <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        run <= 1'b0;
      end else if (start) begin
        dvs       <= divisor;
        quotient  <= dividend;
        remainder <= '0;
        cnt       <= CNT_W'(XLEN - 1);
        run       <= 1'b1;
      end else if (run) begin
        remainder <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quotient  <= {quotient[XLEN-2:0], ge};
        if (cnt == '0) begin
          run  <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// RV32I/RV32M execute stage: ALU ops and multiply write back 1 cycle after accept, divide/remainder XLEN+2.
// in_ready drops while a divide runs; jump_branch_enable blocks issue and aborts an in-flight divide.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int OP_W         = 6,
  parameter int PC_DELAY     = 3,
  parameter int PC_WORD_ADDR = 1
) (
  input logic       clk,
  input logic       reset,
  alu_mdu_if.slave  bus
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN);

  op_e             op;
  logic [XLEN-1:0] a, b, im;
  logic            accept;

  state_e           state;
  logic [CNT_W-1:0] div_cnt;
  logic             in_ready_q, busy_q, write_req_q;
  logic [4:0]       write_addr_q;
  logic [XLEN-1:0]  write_data_q;

  assign op     = op_e'(bus.operation_con[OP_CODE_W-1:0]);
  assign a      = bus.src1_value;
  assign b      = bus.src2_value;
  assign im     = bus.imm;
  assign accept = bus.in_valid & in_ready_q & ~bus.jump_branch_enable;

  // pc arrives from fetch; realign it with the instruction now issuing.
  logic [XLEN-1:0] pc_pipe [PC_DELAY];
  logic [XLEN-1:0] pc_d, auipc_base;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PC_DELAY; i++) pc_pipe[i] <= '0;
    end else begin
      pc_pipe[0] <= bus.pc;
      for (int i = 1; i < PC_DELAY; i++) pc_pipe[i] <= pc_pipe[i-1];
    end
  end

  assign pc_d       = pc_pipe[PC_DELAY-1];
  assign auipc_base = (PC_WORD_ADDR != 0) ? {pc_d[XLEN-3:0], 2'b00} : pc_d;

  // One 2*XLEN multiplier serves all four variants via operand extension.
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;

  assign mul_a_sgn = (op == OP_MULH) || (op == OP_MULHSU);
  assign mul_b_sgn = (op == OP_MULH);
  assign mul_a     = {{XLEN{mul_a_sgn & a[XLEN-1]}}, a};
  assign mul_b     = {{XLEN{mul_b_sgn & b[XLEN-1]}}, b};
  assign prod      = mul_a * mul_b;

  logic [XLEN-1:0] res;
  logic            known, is_div;

  always_comb begin
    res    = '0;
    known  = 1'b1;
    is_div = 1'b0;
    case (op)
      OP_ADD:    res = a + b;
      OP_ADDI:   res = a + im;
      OP_SUB:    res = a - b;
      OP_AND:    res = a & b;
      OP_ANDI:   res = a & im;
      OP_OR:     res = a | b;
      OP_ORI:    res = a | im;
      OP_XOR:    res = a ^ b;
      OP_XORI:   res = a ^ im;
      OP_SLL:    res = a << b[SH_W-1:0];
      OP_SLLI:   res = a << im[SH_W-1:0];
      OP_SRL:    res = a >> b[SH_W-1:0];
      OP_SRLI:   res = a >> im[SH_W-1:0];
      OP_SRA:    res = $signed(a) >>> b[SH_W-1:0];
      OP_SRAI:   res = $signed(a) >>> im[SH_W-1:0];
      OP_SLT:    res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTI:   res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(im)};
      OP_SLTU:   res = {{(XLEN-1){1'b0}}, a < b};
      OP_SLTIU:  res = {{(XLEN-1){1'b0}}, a < im};
      OP_LUI:    res = im;
      OP_AUIPC:  res = im + auipc_base;
      OP_MUL:    res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_div = 1'b1;
      default:   known = 1'b0;
    endcase
  end

  // The divider only sees magnitudes; signs are restored on the way out.
  logic            div_signed, a_neg, b_neg, div_start, div_done;
  logic [XLEN-1:0] dividend, divisor, div_q, div_r;
  logic            q_neg, r_neg, dz, want_rem;
  logic [4:0]      div_rd;
  logic [XLEN-1:0] q_fix, r_fix, div_result;

  assign div_signed = (op == OP_DIV) || (op == OP_REM);
  assign a_neg      = div_signed & a[XLEN-1];
  assign b_neg      = div_signed & b[XLEN-1];
  assign dividend   = a_neg ? -a : a;
  assign divisor    = b_neg ? -b : b;
  assign div_start  = accept & is_div;

  assign q_fix      = dz ? '1 : (q_neg ? -div_q : div_q);
  assign r_fix      = r_neg ? -div_r : div_r;
  assign div_result = want_rem ? r_fix : q_fix;

  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .abort     (bus.jump_branch_enable),
    .dividend  (dividend),
    .divisor   (divisor),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      write_req_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      dz           <= 1'b0;
      want_rem     <= 1'b0;
      div_rd       <= '0;
    end else begin
      write_req_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && is_div) begin
            state      <= ST_DIV_RUN;
            div_cnt    <= CNT_W'(XLEN - 1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            q_neg      <= a_neg ^ b_neg;
            r_neg      <= a_neg;
            dz         <= (b == '0);
            want_rem   <= (op == OP_REM) || (op == OP_REMU);
            div_rd     <= bus.rd;
          end else if (accept) begin
            write_data_q <= res;
            write_addr_q <= known ? bus.rd : 5'd0;
            write_req_q  <= known && (bus.rd != 5'd0);
          end
        end
        ST_DIV_RUN: begin
          if (bus.jump_branch_enable) begin
            state      <= ST_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (div_cnt == '0) begin
            state <= ST_DIV_DONE;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        ST_DIV_DONE: begin
          state      <= ST_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (!bus.jump_branch_enable && div_done) begin
            write_data_q <= div_result;
            write_addr_q <= div_rd;
            write_req_q  <= (div_rd != 5'd0);
          end
        end
        default: begin
          state      <= ST_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.write_req  = write_req_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed vector bench for alu_mdu: single-cycle op table, divide table, abort/reset/AUIPC sequences.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic clk;
  logic reset;
  int   tests;
  int   failed;

  alu_mdu_if #(.XLEN(XLEN), .OP_W(6)) u_if ();

  alu_mdu #(.XLEN(XLEN), .OP_W(6), .PC_DELAY(3), .PC_WORD_ADDR(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        req;
    logic [4:0]  eaddr;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } dvec_t;

  localparam int NV = 19;
  localparam int ND = 10;
  vec_t  vt [NV];
  dvec_t dt [ND];

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] im, input logic [4:0] rd, input logic [31:0] exp,
                              input logic req, input logic [4:0] eaddr);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.im = im; v.rd = rd; v.exp = exp; v.req = req; v.eaddr = eaddr;
    return v;
  endfunction

  function automatic dvec_t mkd(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [31:0] exp);
    dvec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
    end
  endtask

  // Presents one op for one clock edge; returns 1ns after that edge.
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [4:0] rd, input logic jb);
    @(negedge clk);
    u_if.in_valid           = 1'b1;
    u_if.operation_con      = op;
    u_if.src1_value         = a;
    u_if.src2_value         = b;
    u_if.imm                = im;
    u_if.rd                 = rd;
    u_if.jump_branch_enable = jb;
    @(posedge clk);
    #1;
    u_if.in_valid           = 1'b0;
    u_if.jump_branch_enable = 1'b0;
  endtask

  task automatic run_div(input string nm, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int bad;
    bad = 0;
    drive(op, a, b, 32'h0, rd, 1'b0);
    for (int k = 1; k <= XLEN; k++) begin
      @(posedge clk);
      #1;
      if (u_if.write_req || u_if.in_ready || !u_if.busy) bad++;
    end
    check({nm, "_wait"}, 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    check({nm, "_req"}, 32'(u_if.write_req), 32'd1);
    check({nm, "_data"}, u_if.write_data, exp);
    check({nm, "_addr"}, 32'(u_if.write_addr), 32'(rd));
    @(posedge clk);
    #1;
    check({nm, "_ready"}, 32'(u_if.in_ready), 32'd1);
  endtask

  task automatic quiet_window(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (u_if.write_req) seen++;
    end
    check(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests  = 0;
    failed = 0;

    vt[0]  = mk(OP_ADDI,   32'h7FFFFFFF, 32'h0,        32'h1,        5'd5,  32'h80000000, 1'b1, 5'd5);
    vt[1]  = mk(OP_SRA,    32'h80000010, 32'h4,        32'h0,        5'd6,  32'hF8000001, 1'b1, 5'd6);
    vt[2]  = mk(OP_SLT,    32'hFFFFFFFF, 32'h1,        32'h0,        5'd7,  32'h00000001, 1'b1, 5'd7);
    vt[3]  = mk(OP_SLTU,   32'hFFFFFFFF, 32'h1,        32'h0,        5'd8,  32'h00000000, 1'b1, 5'd8);
    vt[4]  = mk(OP_MULH,   32'h80000000, 32'h2,        32'h0,        5'd9,  32'hFFFFFFFF, 1'b1, 5'd9);
    vt[5]  = mk(OP_MULHU,  32'h80000000, 32'h2,        32'h0,        5'd10, 32'h00000001, 1'b1, 5'd10);
    vt[6]  = mk(OP_MUL,    32'h80000000, 32'h2,        32'h0,        5'd11, 32'h00000000, 1'b1, 5'd11);
    vt[7]  = mk(OP_SUB,    32'h00000005, 32'h7,        32'h0,        5'd12, 32'hFFFFFFFE, 1'b1, 5'd12);
    vt[8]  = mk(OP_XORI,   32'hF0F0F0F0, 32'h0,        32'hFFFFFFFF, 5'd13, 32'h0F0F0F0F, 1'b1, 5'd13);
    vt[9]  = mk(OP_SLLI,   32'h00000001, 32'h0,        32'h0000003F, 5'd14, 32'h80000000, 1'b1, 5'd14);
    vt[10] = mk(OP_SRL,    32'h80000000, 32'h21,       32'h0,        5'd15, 32'h40000000, 1'b1, 5'd15);
    vt[11] = mk(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        5'd16, 32'hFFFFFFFF, 1'b1, 5'd16);
    vt[12] = mk(OP_LUI,    32'h0,        32'h0,        32'h12345000, 5'd17, 32'h12345000, 1'b1, 5'd17);
    vt[13] = mk(OP_ADD,    32'h00000001, 32'h2,        32'h0,        5'd0,  32'h00000003, 1'b0, 5'd0);
    vt[14] = mk(6'd63,     32'h12345678, 32'h1,        32'h0,        5'd7,  32'h00000000, 1'b0, 5'd0);
    vt[15] = mk(OP_SLTIU,  32'h00000000, 32'h0,        32'hFFFFFFFF, 5'd18, 32'h00000001, 1'b1, 5'd18);
    vt[16] = mk(OP_AND,    32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        5'd19, 32'h0F000F00, 1'b1, 5'd19);
    vt[17] = mk(OP_AUIPC,  32'h0,        32'h0,        32'h00001000, 5'd20, 32'h00001010, 1'b1, 5'd20);
    vt[18] = mk(OP_SRAI,   32'h7FFFFFF0, 32'h0,        32'h00000004, 5'd21, 32'h07FFFFFF, 1'b1, 5'd21);

    dt[0] = mkd(OP_DIV,  32'hFFFFFFF9, 32'h00000002, 5'd3,  32'hFFFFFFFD);
    dt[1] = mkd(OP_REM,  32'hFFFFFFF9, 32'h00000002, 5'd4,  32'hFFFFFFFF);
    dt[2] = mkd(OP_DIVU, 32'h00000005, 32'h00000000, 5'd5,  32'hFFFFFFFF);
    dt[3] = mkd(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000);
    dt[4] = mkd(OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h00000000);
    dt[5] = mkd(OP_REMU, 32'h00000064, 32'h00000007, 5'd8,  32'h00000002);
    dt[6] = mkd(OP_DIV,  32'h00000007, 32'hFFFFFFFE, 5'd9,  32'hFFFFFFFD);
    dt[7] = mkd(OP_REM,  32'h00000007, 32'hFFFFFFFE, 5'd10, 32'h00000001);
    dt[8] = mkd(OP_DIV,  32'hFFFFFFFB, 32'h00000000, 5'd11, 32'hFFFFFFFF);
    dt[9] = mkd(OP_REM,  32'hFFFFFFFB, 32'h00000000, 5'd12, 32'hFFFFFFFB);

    reset                   = 1'b1;
    u_if.in_valid           = 1'b0;
    u_if.jump_branch_enable = 1'b0;
    u_if.pc                 = 32'h4;
    u_if.src1_value         = '0;
    u_if.src2_value         = '0;
    u_if.imm                = '0;
    u_if.rd                 = '0;
    u_if.operation_con      = '0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_req",   32'(u_if.write_req),  32'd0);
    check("rst_addr",  32'(u_if.write_addr), 32'd0);
    check("rst_data",  u_if.write_data,      32'd0);
    check("rst_busy",  32'(u_if.busy),       32'd0);
    check("rst_ready", 32'(u_if.in_ready),   32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].op, vt[i].a, vt[i].b, vt[i].im, vt[i].rd, 1'b0);
      check($sformatf("v%0d_req", i),  32'(u_if.write_req),  32'(vt[i].req));
      check($sformatf("v%0d_data", i), u_if.write_data,      vt[i].exp);
      check($sformatf("v%0d_addr", i), 32'(u_if.write_addr), 32'(vt[i].eaddr));
    end
    @(posedge clk);
    #1;
    check("strobe_one_cycle", 32'(u_if.write_req), 32'd0);

    // Flushed issue must not produce a write.
    drive(OP_ADD, 32'h1, 32'h1, 32'h0, 5'd3, 1'b1);
    check("flush_no_accept", 32'(u_if.write_req), 32'd0);

    // pc changes, but AUIPC uses the value from PC_DELAY cycles back.
    @(negedge clk);
    u_if.pc = 32'h8;
    drive(OP_AUIPC, 32'h0, 32'h0, 32'h00001000, 5'd22, 1'b0);
    check("auipc_old_pc", u_if.write_data, 32'h00001010);
    repeat (2) @(posedge clk);
    drive(OP_AUIPC, 32'h0, 32'h0, 32'h00001000, 5'd22, 1'b0);
    check("auipc_new_pc", u_if.write_data, 32'h00001020);

    for (int i = 0; i < ND; i++) begin
      run_div($sformatf("d%0d", i), dt[i].op, dt[i].a, dt[i].b, dt[i].rd, dt[i].exp);
    end

    // Abort a divide with a flush in cycle 10 after accept.
    drive(OP_DIV, 32'd100, 32'd3, 32'h0, 5'd9, 1'b0);
    for (int k = 1; k <= 9; k++) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(u_if.busy), 32'd1);
    @(negedge clk);
    u_if.jump_branch_enable = 1'b1;
    @(posedge clk);
    #1;
    u_if.jump_branch_enable = 1'b0;
    check("abort_busy",  32'(u_if.busy),      32'd0);
    check("abort_ready", 32'(u_if.in_ready),  32'd1);
    check("abort_req",   32'(u_if.write_req), 32'd0);
    quiet_window("abort_no_late_write", 40);
    drive(OP_ADD, 32'd2, 32'd3, 32'h0, 5'd4, 1'b0);
    check("post_abort_req",  32'(u_if.write_req),  32'd1);
    check("post_abort_data", u_if.write_data,      32'd5);
    check("post_abort_addr", 32'(u_if.write_addr), 32'd4);

    // Reset in the middle of a divide.
    drive(OP_DIVU, 32'd1000, 32'd7, 32'h0, 5'd13, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_req",   32'(u_if.write_req),  32'd0);
    check("mrst_addr",  32'(u_if.write_addr), 32'd0);
    check("mrst_data",  u_if.write_data,      32'd0);
    check("mrst_busy",  32'(u_if.busy),       32'd0);
    check("mrst_ready", 32'(u_if.in_ready),   32'd1);
    @(negedge clk);
    reset = 1'b0;
    quiet_window("mrst_no_late_write", 40);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
